// File: rtl/tns_pkg.sv
// Shared types and code-mapping helpers for the TNS crosstalk-avoidance link.
// The receiver decoder imports the same tns_map/tns_unmap pair, so both ends
// always agree on the codebook.
package tns_pkg;

    typedef logic [2:0] tns_grp_t;
    typedef logic [2:0] tns_digit_t;

    typedef enum logic [1:0] {IDLE, CONV, EMIT} tns_state_t;

    localparam int TNS_RADIX = 7;

    // Digit -> codeword. The skipped code is the one forbidden after msb r
    // (100 after r=0, 011 after r=1), so digits at or above it shift up by one.
    function automatic tns_grp_t tns_map(input tns_digit_t d, input logic r);
        tns_digit_t lim;
        lim = r ? 3'd3 : 3'd4;
        return (d < lim) ? tns_grp_t'(d) : tns_grp_t'(d + 3'd1);
    endfunction

    // Codeword -> digit, inverse of tns_map for the same previous msb.
    function automatic tns_digit_t tns_unmap(input tns_grp_t g, input logic r);
        tns_grp_t lim;
        lim = r ? 3'd3 : 3'd4;
        return (g < lim) ? tns_digit_t'(g) : tns_digit_t'(g - 3'd1);
    endfunction

    // Integer power used for the legal-range limit at elaboration.
    function automatic longint unsigned tns_pow(input int b, input int e);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < e; i++) p = p * longint'(b);
        return p;
    endfunction

endpackage

// File: rtl/tns_enc_stream_group_map.sv
// One TSV group's encoder: radix-7 digit plus the group's current msb in,
// codeword that avoids the msb-dependent forbidden transition out.
module tns_group_map
    import tns_pkg::*;
(
    input  tns_digit_t d,
    input  logic       r,
    output tns_grp_t   g
);

    // Pure lookup; shares the package function with the receiver.
    assign g = tns_map(d, r);

endmodule

// File: rtl/tns_enc_stream.sv
// Handshaked TNS encoder: converts a binary word to N_GROUPS radix-7 digits
// (one per cycle), then drives all 3-bit TSV groups in one register update.
// Optional macro TNS_SELFCHECK_EN adds an on-chip decoder and selfcheck_err.
module tns_enc_stream
    import tns_pkg::*;
#(
    parameter int N_GROUPS = 10,
    parameter int DATA_W   = 29
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [3*N_GROUPS-1:0]   tsv,
    output logic                    tsv_valid,
    output logic                    range_err
`ifdef TNS_SELFCHECK_EN
    ,
    output logic                    selfcheck_err
`endif
);

    localparam longint unsigned LIMIT = tns_pow(TNS_RADIX, N_GROUPS);
    localparam int              KW    = $clog2(N_GROUPS + 1);

    // The input word must be able to express every legal digit combination.
    if (DATA_W < 64 && (64'd1 << DATA_W) < LIMIT) begin : g_width_chk
        $error("tns_enc_stream: DATA_W too small for N_GROUPS");
    end

    tns_state_t                          state, state_nxt;
    logic [DATA_W-1:0]                   acc;
    logic [DATA_W-1:0]                   acc_div;
    tns_digit_t                          acc_mod;
    logic [KW-1:0]                       k;
    logic [N_GROUPS-1:0][2:0]            digit;
    logic [N_GROUPS-1:0][2:0]            grp_nxt;
    logic                                accept;
    logic                                in_range;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign in_range = (64'(in_data) < LIMIT);

    // Constant divisor: synthesis reduces these to a fixed divider network.
    assign acc_div = acc / DATA_W'(TNS_RADIX);
    assign acc_mod = tns_digit_t'(acc % DATA_W'(TNS_RADIX));

    // Each group's next codeword depends only on its digit and its own current msb.
    for (genvar j = 0; j < N_GROUPS; j++) begin : g_map
        tns_group_map u_map (
            .d (digit[j]),
            .r (tsv[3*j+2]),
            .g (grp_nxt[j])
        );
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: out-of-range words are dropped without leaving IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && in_range) state_nxt = CONV;
            CONV:    if (k == KW'(N_GROUPS - 1)) state_nxt = EMIT;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: digit extraction, bundle update and the one-cycle status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            k         <= '0;
            digit     <= '0;
            tsv       <= '0;
            tsv_valid <= 1'b0;
            range_err <= 1'b0;
        end else begin
            tsv_valid <= 1'b0;
            range_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_range) begin
                            acc <= in_data;
                            k   <= '0;
                        end else begin
                            range_err <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    digit[k] <= acc_mod;
                    acc      <= acc_div;
                    k        <= k + 1'b1;
                end
                EMIT: begin
                    tsv       <= grp_nxt;
                    tsv_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TNS_SELFCHECK_EN
    logic [DATA_W-1:0]  word_q;
    logic [63:0]        dec;

    // Decode the codewords about to be emitted against the msbs they replace.
    always_comb begin
        dec = '0;
        for (int j = N_GROUPS - 1; j >= 0; j--)
            dec = dec * 64'(TNS_RADIX) + 64'(tns_unmap(grp_nxt[j], tsv[3*j+2]));
    end

    // Hold the accepted word and flag a decode mismatch alongside tsv_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q        <= '0;
            selfcheck_err <= 1'b0;
        end else begin
            if (accept && in_range) word_q <= in_data;
            selfcheck_err <= (state == EMIT) && (dec != 64'(word_q));
        end
    end
`endif

endmodule

// File: tb/tb_tns_enc_stream.sv
// Directed + random bench for tns_enc_stream (N_GROUPS=10, DATA_W=29).
module tb_tns_enc_stream;

    localparam int              N     = 10;
    localparam int              W     = 29;
    localparam int              TW    = 3 * N;
    localparam longint unsigned LIMIT = 64'd282475249;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data  = '0;
    logic          in_ready;
    logic [TW-1:0] tsv;
    logic          tsv_valid;
    logic          range_err;
`ifdef TNS_SELFCHECK_EN
    logic          selfcheck_err;
    int            sc_pulses = 0;
`endif

    int ntests = 0;
    int nfail  = 0;

    tns_enc_stream #(.N_GROUPS(N), .DATA_W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tsv       (tsv),
        .tsv_valid (tsv_valid),
        .range_err (range_err)
`ifdef TNS_SELFCHECK_EN
        ,
        .selfcheck_err (selfcheck_err)
`endif
    );

    always #5 clock = ~clock;

`ifdef TNS_SELFCHECK_EN
    always @(posedge clock) if (selfcheck_err === 1'b1) sc_pulses++;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference codebook, written out as tables.
    function automatic logic [2:0] map_m(input logic [2:0] d, input logic r);
        if (!r) case (d) 3'd4: return 3'd5; 3'd5: return 3'd6; 3'd6: return 3'd7; default: return d; endcase
        else    case (d) 3'd3: return 3'd4; 3'd4: return 3'd5; 3'd5: return 3'd6; 3'd6: return 3'd7; default: return d; endcase
    endfunction

    function automatic logic [2:0] unmap_m(input logic [2:0] g, input logic r);
        if (!r) case (g) 3'd5: return 3'd4; 3'd6: return 3'd5; 3'd7: return 3'd6; 3'd4: return 3'd7; default: return g; endcase
        else    case (g) 3'd4: return 3'd3; 3'd5: return 3'd4; 3'd6: return 3'd5; 3'd7: return 3'd6; 3'd3: return 3'd7; default: return g; endcase
    endfunction

    function automatic logic [TW-1:0] enc_model(input longint unsigned w, input logic [TW-1:0] prev);
        logic [TW-1:0] t;
        t = '0;
        for (int j = 0; j < N; j++) begin
            t[3*j +: 3] = map_m(3'(w % 7), prev[3*j+2]);
            w = w / 7;
        end
        return t;
    endfunction

    // Accept one word; report cycles from accept edge to the tsv_valid cycle.
    task automatic send(input logic [W-1:0] w, output int lat, output logic rerr);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
        chk("ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        rerr = range_err;
        lat  = 0;
        if (rerr !== 1'b1) begin
            do begin tick(); lat++; end while (tsv_valid !== 1'b1 && lat < 40);
        end
    endtask

    initial begin
        int            lat;
        int            seen;
        logic          rerr;
        logic [TW-1:0] prev;
        logic [TW-1:0] snap;
        longint unsigned w, dec;
        logic          ok;

        // Reset held two cycles.
        tick(); tick();
        chk("rst_tsv", 64'(tsv), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_tsv_valid", 64'(tsv_valid), 64'd0);
        chk("rst_range_err", 64'(range_err), 64'd0);
        reset = 1'b0;
        tick();

        // Word 4 from all-zero bundle: group0 101.
        send(W'(4), lat, rerr);
        chk("w4_rerr", 64'(rerr), 64'd0);
        chk("w4_latency", 64'(lat), 64'(N + 1));
        chk("w4_tsv", 64'(tsv), 64'h5);
        tick();
        chk("w4_single_pulse", 64'(tsv_valid), 64'd0);

        // Word 3 after msb=1 must use 100, not 011.
        send(W'(3), lat, rerr);
        chk("w3_tsv", 64'(tsv), 64'h4);

        send(W'(0), lat, rerr);
        chk("w0_tsv", 64'(tsv), 64'h0);

        // All digits 6 -> every wire high.
        send(W'(282475248), lat, rerr);
        chk("max_latency", 64'(lat), 64'(N + 1));
        chk("max_tsv", 64'(tsv), 64'h3FFFFFFF);

        // First out-of-range word: dropped with a single range_err pulse.
        send(W'(282475249), lat, rerr);
        chk("oor_rerr", 64'(rerr), 64'd1);
        chk("oor_ready", 64'(in_ready), 64'd1);
        chk("oor_tsv_hold", 64'(tsv), 64'h3FFFFFFF);
        seen = 0;
        tick();
        chk("oor_rerr_pulse", 64'(range_err), 64'd0);
        for (int i = 0; i < 14; i++) begin if (tsv_valid === 1'b1) seen++; tick(); end
        chk("oor_no_valid", 64'(seen), 64'd0);
        chk("oor_tsv_still", 64'(tsv), 64'h3FFFFFFF);

        // Mixed digits from an all-ones bundle exercise the msb=1 codebook.
        w    = 0;
        for (int j = N - 1; j >= 0; j--) w = w * 7 + longint'(j % 7);
        prev = tsv;
        send(W'(w), lat, rerr);
        chk("mixed_tsv", 64'(tsv), 64'(enc_model(w, prev)));

        // Reset in the 5th CONV cycle discards the word.
        snap = tsv;
        chk("pre_rst_nonzero", 64'(snap != '0), 64'd1);
        in_valid = 1'b1;
        in_data  = W'(12345);
        tick();
        in_valid = 1'b0;
        chk("conv_not_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        chk("midrst_tsv", 64'(tsv), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_tsv_valid", 64'(tsv_valid), 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (tsv_valid === 1'b1) seen++; end
        chk("midrst_no_valid", 64'(seen), 64'd0);

        // Random in-range words with idle gaps; decode and check forbidden codes.
        for (int t = 0; t < 300; t++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            w    = longint'($urandom_range(0, 32'(LIMIT - 1)));
            prev = tsv;
            send(W'(w), lat, rerr);
            chk("rnd_latency", 64'(lat), 64'(N + 1));
            dec = 0;
            ok  = 1'b1;
            for (int j = N - 1; j >= 0; j--) begin
                if (tsv[3*j +: 3] == (prev[3*j+2] ? 3'd3 : 3'd4)) ok = 1'b0;
                dec = dec * 7 + longint'(unmap_m(tsv[3*j +: 3], prev[3*j+2]));
            end
            chk("rnd_forbidden", 64'(ok), 64'd1);
            chk("rnd_decode", dec, w);
        end

`ifdef TNS_SELFCHECK_EN
        chk("selfcheck_quiet", 64'(sc_pulses), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
